// File: rtl/bp_perf_monitor_if.sv
// bp_perf_monitor_if: hazard/prediction taps and counter read port of the perf monitor
interface bp_perf_monitor_if #(parameter int CNT_WIDTH = 32);
  logic en_i, clear_i, StallD_i, FlushD_i, FlushE_i;
  logic [31:0] PCF_i;
  logic BranchTakenF_i, BranchE_i, JumpE_i, ActualTakenE_i;
  logic [4:0] rd_sel_i;
  logic [CNT_WIDTH-1:0] rd_data_o;
  logic overflow_o;
  modport master (
    output en_i, clear_i, StallD_i, FlushD_i, FlushE_i, PCF_i, BranchTakenF_i,
           BranchE_i, JumpE_i, ActualTakenE_i, rd_sel_i,
    input  rd_data_o, overflow_o
  );
  modport slave (
    input  en_i, clear_i, StallD_i, FlushD_i, FlushE_i, PCF_i, BranchTakenF_i,
           BranchE_i, JumpE_i, ActualTakenE_i, rd_sel_i,
    output rd_data_o, overflow_o
  );
endinterface

// File: rtl/bp_perf_monitor.sv
// bp_perf_monitor: tracks fetch predictions to Execute and counts hits, misses and per-PC mispredicts
module bp_perf_monitor #(
  parameter int CNT_WIDTH = 32,
  parameter int NUM_HIST  = 8,
  parameter bit SATURATE  = 1'b1
) (
  input logic              clk,
  input logic              reset,
  bp_perf_monitor_if.slave bus
);
  localparam int HW = NUM_HIST > 1 ? $clog2(NUM_HIST) : 1;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  logic dvalid_q, dvalid_d, dpred_q, dpred_d, evalid_q, evalid_d, epred_q, epred_d;
  logic [HW-1:0] dpc_q, dpc_d, epc_q, epc_d, hidx;
  cnt_t cnt_q [6];
  cnt_t cnt_d [6];
  cnt_t hist_q [NUM_HIST];
  cnt_t hist_d [NUM_HIST];
  logic [5:0] inc;
  logic [NUM_HIST-1:0] hinc;
  logic ovf_q, ovf_d;
  cnt_t rd_q, rd_d;
  logic unused_pc;
  function automatic cnt_t bump(cnt_t c, logic i);
    return !i ? c : (SATURATE && &c) ? c : c + 1'b1;
  endfunction
  // Only the PC bits that select a histogram bucket travel down the pipe
  assign unused_pc = ^{bus.PCF_i[31:HW+2], bus.PCF_i[1:0]};
  assign hidx = NUM_HIST > 1 ? epc_q : '0;
  assign bus.rd_data_o = rd_q;
  assign bus.overflow_o = ovf_q;
  always_comb begin
    dvalid_d = bus.FlushD_i ? 1'b0 : bus.StallD_i ? dvalid_q : 1'b1;
    dpred_d = (bus.FlushD_i || bus.StallD_i) ? dpred_q : bus.BranchTakenF_i;
    dpc_d = (bus.FlushD_i || bus.StallD_i) ? dpc_q : bus.PCF_i[HW+1:2];
    evalid_d = (bus.FlushE_i || bus.StallD_i) ? 1'b0 : dvalid_q;
    epred_d = (bus.FlushE_i || bus.StallD_i) ? epred_q : dpred_q;
    epc_d = (bus.FlushE_i || bus.StallD_i) ? epc_q : dpc_q;
  end
  always_comb begin
    inc[0] = bus.en_i;
    inc[1] = bus.en_i && evalid_q;
    inc[4] = inc[1] && bus.JumpE_i;
    inc[5] = inc[4] && !epred_q;
    inc[2] = inc[1] && !bus.JumpE_i && bus.BranchE_i;
    inc[3] = inc[2] && (epred_q != bus.ActualTakenE_i);
    hinc = '0;
    ovf_d = ovf_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = bump(cnt_q[i], inc[i]);
      ovf_d = ovf_d | (inc[i] & (&cnt_q[i]));
    end
    for (int k = 0; k < NUM_HIST; k++) begin
      hinc[k] = inc[3] && hidx == HW'(k);
      hist_d[k] = bump(hist_q[k], hinc[k]);
      ovf_d = ovf_d | (hinc[k] & (&hist_q[k]));
    end
    if (bus.clear_i) begin
      for (int i = 0; i < 6; i++) cnt_d[i] = '0;
      for (int k = 0; k < NUM_HIST; k++) hist_d[k] = '0;
      ovf_d = 1'b0;
    end
    rd_d = '0;
    for (int i = 0; i < 6; i++) if (bus.rd_sel_i == 5'(i)) rd_d = cnt_q[i];
    for (int k = 0; k < NUM_HIST; k++) if (bus.rd_sel_i == 5'(16 + k)) rd_d = hist_q[k];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {dvalid_q, dpred_q, evalid_q, epred_q, ovf_q} <= '0;
      dpc_q <= '0;
      epc_q <= '0;
      rd_q <= '0;
      cnt_q <= '{default: '0};
      hist_q <= '{default: '0};
    end else begin
      {dvalid_q, dpred_q, evalid_q, epred_q, ovf_q} <= {dvalid_d, dpred_d, evalid_d, epred_d, ovf_d};
      dpc_q <= dpc_d;
      epc_q <= epc_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      hist_q <= hist_d;
    end
  end
endmodule

// File: tb/tb_bp_perf_monitor.sv
// tb_bp_perf_monitor: table-driven branch/jump scenarios plus stall, flush, saturate/wrap and clear sequences
module tb_bp_perf_monitor;
  logic clk = 1'b0;
  logic reset, en, clr, stall_d, flush_d, flush_e, btf, br, jmp, act;
  logic [31:0] pcf;
  logic [4:0] sel;
  int total = 0, bad = 0;
  typedef struct packed { logic [1:0] dut; logic [63:0] exp; } sb_t;
  sb_t sbq[$];
  typedef struct { logic [31:0] pc; logic btf, br, jmp, act; int br_n, bm_n, j_n, jm_n, hidx, hval; } vec_t;
  vec_t tbl[8];
  bp_perf_monitor_if #(.CNT_WIDTH(32)) i_main();
  bp_perf_monitor_if #(.CNT_WIDTH(8)) i_sat();
  bp_perf_monitor_if #(.CNT_WIDTH(8)) i_wrap();
  assign {i_main.en_i, i_main.clear_i, i_main.StallD_i, i_main.FlushD_i, i_main.FlushE_i, i_main.PCF_i, i_main.BranchTakenF_i, i_main.BranchE_i, i_main.JumpE_i, i_main.ActualTakenE_i, i_main.rd_sel_i} = {en, clr, stall_d, flush_d, flush_e, pcf, btf, br, jmp, act, sel};
  assign {i_sat.en_i, i_sat.clear_i, i_sat.StallD_i, i_sat.FlushD_i, i_sat.FlushE_i, i_sat.PCF_i, i_sat.BranchTakenF_i, i_sat.BranchE_i, i_sat.JumpE_i, i_sat.ActualTakenE_i, i_sat.rd_sel_i} = {en, clr, stall_d, flush_d, flush_e, pcf, btf, br, jmp, act, sel};
  assign {i_wrap.en_i, i_wrap.clear_i, i_wrap.StallD_i, i_wrap.FlushD_i, i_wrap.FlushE_i, i_wrap.PCF_i, i_wrap.BranchTakenF_i, i_wrap.BranchE_i, i_wrap.JumpE_i, i_wrap.ActualTakenE_i, i_wrap.rd_sel_i} = {en, clr, stall_d, flush_d, flush_e, pcf, btf, br, jmp, act, sel};
  bp_perf_monitor #(.CNT_WIDTH(32), .NUM_HIST(8), .SATURATE(1'b1)) u_main (.clk(clk), .reset(reset), .bus(i_main.slave));
  bp_perf_monitor #(.CNT_WIDTH(8), .NUM_HIST(8), .SATURATE(1'b1)) u_sat (.clk(clk), .reset(reset), .bus(i_sat.slave));
  bp_perf_monitor #(.CNT_WIDTH(8), .NUM_HIST(8), .SATURATE(1'b0)) u_wrap (.clk(clk), .reset(reset), .bus(i_wrap.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic rd(input int d, input logic [4:0] s, input logic [63:0] e, input string n);
    sb_t x;
    x.dut = 2'(d);
    x.exp = e;
    sbq.push_back(x);
    sel = s;
    @(negedge clk);
    x = sbq.pop_front();
    chk(n, x.dut == 2'd0 ? 64'(i_main.rd_data_o) : x.dut == 2'd1 ? 64'(i_sat.rd_data_o) : 64'(i_wrap.rd_data_o), x.exp);
  endtask
  task automatic rst_all();
    reset = 1'b1;
    {en, clr, stall_d, flush_d, flush_e, btf, br, jmp, act} = '0;
    pcf = '0;
    sel = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    tbl[0] = '{32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 4, 0};
    tbl[1] = '{32'h0C, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 0, 0, 3, 1};
    tbl[2] = '{32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1, 1, 0, 0};
    tbl[3] = '{32'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 7, 1};
    tbl[4] = '{32'h24, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0, 1, 0};
    tbl[5] = '{32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 4, 0};
    tbl[6] = '{32'h2C, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 3, 1};
    tbl[7] = '{32'h08, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 2, 0};
    rst_all();
    chk("reset rd_data", 64'(i_main.rd_data_o), 64'd0);
    chk("reset overflow", 64'(i_main.overflow_o), 64'd0);
    en = 1'b1;
    flush_e = 1'b1;
    repeat (10) @(negedge clk);
    {en, flush_e} = '0;
    rd(0, 5'd0, 64'd10, "idle cycle");
    rd(0, 5'd1, 64'd0, "idle instr");
    rd(0, 5'd8, 64'd0, "unmapped sel8");
    chk("idle overflow", 64'(i_main.overflow_o), 64'd0);
    for (int r = 0; r < 8; r++) begin
      rst_all();
      en = 1'b1;
      pcf = tbl[r].pc;
      btf = tbl[r].btf;
      @(negedge clk);
      pcf = tbl[r].pc + 32'd4;
      btf = !tbl[r].btf;
      @(negedge clk);
      {br, jmp, act} = {tbl[r].br, tbl[r].jmp, tbl[r].act};
      @(negedge clk);
      {en, br, jmp, act} = '0;
      rd(0, 5'd0, 64'd3, $sformatf("row%0d cycle", r));
      rd(0, 5'd1, 64'd1, $sformatf("row%0d instr", r));
      rd(0, 5'd2, 64'(tbl[r].br_n), $sformatf("row%0d branch", r));
      rd(0, 5'd3, 64'(tbl[r].bm_n), $sformatf("row%0d branch_miss", r));
      rd(0, 5'd4, 64'(tbl[r].j_n), $sformatf("row%0d jump", r));
      rd(0, 5'd5, 64'(tbl[r].jm_n), $sformatf("row%0d jump_miss", r));
      rd(0, 5'(16 + tbl[r].hidx), 64'(tbl[r].hval), $sformatf("row%0d hist", r));
      rd(0, 5'(24 + tbl[r].hidx), 64'd0, $sformatf("row%0d hist out of range", r));
    end
    rst_all();
    en = 1'b1;
    pcf = 32'h20;
    btf = 1'b1;
    @(negedge clk);
    stall_d = 1'b1;
    btf = 1'b0;
    pcf = 32'h24;
    repeat (2) @(negedge clk);
    stall_d = 1'b0;
    @(negedge clk);
    {br, act} = 2'b11;
    @(negedge clk);
    {en, br, act} = '0;
    rd(0, 5'd1, 64'd1, "stall instr");
    rd(0, 5'd2, 64'd1, "stall branch");
    rd(0, 5'd3, 64'd0, "stall pred kept");
    rst_all();
    en = 1'b1;
    pcf = 32'h20;
    btf = 1'b1;
    @(negedge clk);
    {flush_d, stall_d} = 2'b11;
    btf = 1'b0;
    @(negedge clk);
    {flush_d, stall_d} = '0;
    @(negedge clk);
    {br, act} = 2'b11;
    @(negedge clk);
    {en, br, act} = '0;
    rd(0, 5'd1, 64'd0, "flush instr");
    rd(0, 5'd2, 64'd0, "flush branch");
    rst_all();
    en = 1'b1;
    flush_e = 1'b1;
    repeat (255) @(negedge clk);
    en = 1'b0;
    chk("sat no overflow at 255", 64'(i_sat.overflow_o), 64'd0);
    chk("wrap no overflow at 255", 64'(i_wrap.overflow_o), 64'd0);
    rd(1, 5'd0, 64'd255, "sat cycle 255");
    rd(2, 5'd0, 64'd255, "wrap cycle 255");
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("sat overflow", 64'(i_sat.overflow_o), 64'd1);
    chk("wrap overflow", 64'(i_wrap.overflow_o), 64'd1);
    rd(1, 5'd0, 64'd255, "sat cycle held");
    rd(2, 5'd0, 64'd0, "wrap cycle to 0");
    en = 1'b1;
    repeat (44) @(negedge clk);
    en = 1'b0;
    rd(1, 5'd0, 64'd255, "sat cycle 300");
    rd(2, 5'd0, 64'd44, "wrap cycle 300");
    rd(0, 5'd0, 64'd300, "main cycle 300");
    rd(1, 5'd1, 64'd0, "sat instr");
    chk("main no overflow", 64'(i_main.overflow_o), 64'd0);
    chk("sat overflow sticky", 64'(i_sat.overflow_o), 64'd1);
    flush_e = 1'b0;
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    {br, act, clr} = 3'b111;
    @(negedge clk);
    {br, act, clr, en} = '0;
    chk("clear sat overflow", 64'(i_sat.overflow_o), 64'd0);
    chk("clear wrap overflow", 64'(i_wrap.overflow_o), 64'd0);
    rd(1, 5'd0, 64'd0, "clear sat cycle");
    rd(2, 5'd0, 64'd0, "clear wrap cycle");
    rd(0, 5'd0, 64'd0, "clear main cycle");
    rd(0, 5'd1, 64'd0, "clear main instr");
    rd(0, 5'd2, 64'd0, "clear main branch");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
